// File: rtl/window_line_buffer_3x3.sv
// Raster-order pixel stream to 3x3 sliding windows (stride 1, valid padding).
// Two line memories feed the top/middle rows of a 3x3 shift array; the bottom row comes straight from pix_in.
module window_line_buffer_3x3 #(
  parameter  int IMG_WIDTH  = 112,
  parameter  int IMG_HEIGHT = 112,
  parameter  int DATA_W     = 8,
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [DATA_W-1:0]      pix_in,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  output logic [8:0][DATA_W-1:0] window_out,
  output logic                   win_valid,
  input  logic                   win_ready,
  output logic [RW-1:0]          out_row,
  output logic [CW-1:0]          out_col,
  output logic                   frame_done
);

  logic [CW-1:0]          col_q, col_d, out_col_q, out_col_d;
  logic [RW-1:0]          row_q, row_d, out_row_q, out_row_d;
  logic                   win_valid_q, win_valid_d;
  logic                   frame_done_q, frame_done_d;
  logic [8:0][DATA_W-1:0] arr_q, arr_d;
  logic [DATA_W-1:0]      line0_q [IMG_WIDTH];
  logic [DATA_W-1:0]      line1_q [IMG_WIDTH];

  logic accept, last_col, last_row, produce;

  assign pix_ready = !reset && (!win_valid_q || win_ready);
  assign accept    = pix_valid && pix_ready && !clear;
  assign last_col  = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row  = (row_q == RW'(IMG_HEIGHT - 1));
  assign produce   = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    win_valid_d  = win_valid_q;
    frame_done_d = 1'b0;
    arr_d        = arr_q;
    if (accept) begin
      col_d = last_col ? '0 : col_q + 1'b1;
      if (last_col) begin
        row_d = last_row ? '0 : row_q + 1'b1;
      end
      frame_done_d = last_col && last_row;
      // Each array row shifts left; the new right column is {line0[c], line1[c], pix_in}.
      arr_d[0] = arr_q[1];
      arr_d[1] = arr_q[2];
      arr_d[2] = line0_q[col_q];
      arr_d[3] = arr_q[4];
      arr_d[4] = arr_q[5];
      arr_d[5] = line1_q[col_q];
      arr_d[6] = arr_q[7];
      arr_d[7] = arr_q[8];
      arr_d[8] = pix_in;
      win_valid_d = produce;
      if (produce) begin
        out_row_d = row_q - RW'(2);
        out_col_d = col_q - CW'(2);
      end
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      arr_q        <= '0;
    end else if (clear) begin
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      arr_q        <= arr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) begin
      line0_q[col_q] <= line1_q[col_q];
      line1_q[col_q] <= pix_in;
    end
  end

  // The array only moves on accept, so it doubles as the held output window.
  assign window_out = arr_q;
  assign win_valid  = win_valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_line_buffer_3x3.sv
// Scoreboard bench for window_line_buffer_3x3 on a 5x4 image; the reference model
// keeps the whole frame in a 2D array and cuts windows out of it directly.
module tb_window_line_buffer_3x3;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int DW = 8;

  logic                 clock = 1'b0;
  logic                 reset, clear, pix_valid, pix_ready;
  logic [DW-1:0]        pix_in;
  logic [8:0][DW-1:0]   window_out;
  logic                 win_valid, win_ready, frame_done;
  logic [1:0]           out_row;
  logic [2:0]           out_col;

  window_line_buffer_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .clear(clear), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .window_out(window_out),
    .win_valid(win_valid), .win_ready(win_ready), .out_row(out_row),
    .out_col(out_col), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [8:0][DW-1:0] w;
    int                 row;
    int                 col;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] img [H][W];
  int            mr, mc;
  int            checks = 0, errors = 0;
  int            win_cnt = 0, held_cnt = 0;
  int            rdy_mode = 0;
  int            stall_left = 0;
  bit            stall_used = 0;

  task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic model_accept(input logic [DW-1:0] v, output bit comp, output bit last);
    exp_t e;
    img[mr][mc] = v;
    comp = (mr >= 2) && (mc >= 2);
    last = (mr == H - 1) && (mc == W - 1);
    if (comp) begin
      for (int k = 0; k < 9; k++) e.w[k] = img[mr - 2 + k / 3][mc - 2 + k % 3];
      e.row = mr - 2;
      e.col = mc - 2;
      exp_q.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
      if (mr == H) mr = 0;
    end
  endtask

  task automatic send_pix(input logic [DW-1:0] v, input bit gaps);
    int  waitc;
    bit  comp, last;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1) begin
        pix_valid = 1'b0;
        step();
      end
    end
    pix_valid = 1'b1;
    pix_in    = v;
    #1;
    waitc = 0;
    while (!pix_ready && waitc < 200) begin
      waitc++;
      step();
      #1;
    end
    if (!pix_ready) begin
      check("pix_accept_timeout", 0, 1);
      pix_valid = 1'b0;
      step();
      return;
    end
    model_accept(v, comp, last);
    step();
    pix_valid = 1'b0;
    if (comp) check("win_latency", win_valid, 1);
    check("frame_done", frame_done, last);
  endtask

  task automatic ramp(input int base, input bit gaps);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        send_pix(DW'(base + 5 * r + c), gaps);
  endtask

  task automatic drain();
    int waitc = 0;
    while (exp_q.size() != 0 && waitc < 100) begin
      waitc++;
      step();
    end
    check("drain_empty", exp_q.size(), 0);
    step();
  endtask

  // Consumer side: win_ready pattern selected by rdy_mode.
  initial begin
    win_ready = 1'b1;
    forever begin
      @(negedge clock);
      case (rdy_mode)
        1: win_ready = ($urandom_range(1, 0) == 1);
        2: begin
          if (win_valid && !stall_used) begin
            stall_used = 1;
            stall_left = 3;
          end
          if (stall_left > 0) begin
            win_ready = 1'b0;
            stall_left--;
          end else begin
            win_ready = 1'b1;
          end
        end
        3:       win_ready = 1'b0;
        default: win_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks hold stability.
  bit                 held;
  logic [8:0][DW-1:0] hw;
  logic [1:0]         hr;
  logic [2:0]         hc;
  exp_t               me;
  initial begin
    held = 0;
    forever begin
      @(negedge clock);
      #3;
      if (reset) begin
        held = 0;
        continue;
      end
      if (held) begin
        check("hold_valid", win_valid, 1);
        check("hold_window", window_out, hw);
        check("hold_pos", {out_row, out_col}, {hr, hc});
      end
      held = 0;
      if (win_valid && !win_ready) begin
        check("stall_pix_ready", pix_ready, 0);
        held = 1;
        hw = window_out;
        hr = out_row;
        hc = out_col;
        held_cnt++;
      end
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_window", 1, 0);
        end else begin
          me = exp_q.pop_front();
          check("window", window_out, me.w);
          check("out_row", out_row, me.row);
          check("out_col", out_col, me.col);
        end
        win_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int start;
  initial begin
    reset = 1'b1; clear = 1'b0; pix_valid = 1'b0; pix_in = '0;
    mr = 0; mc = 0;
    repeat (3) step();
    check("rst_win_valid", win_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_window", window_out, 0);
    check("rst_pos", {out_row, out_col}, 0);
    check("rst_pix_ready", pix_ready, 0);
    reset = 1'b0;
    step();

    start = win_cnt;
    ramp(0, 0);
    drain();
    check("ramp_windows", win_cnt - start, 6);

    rdy_mode = 2; stall_used = 0; start = win_cnt; held_cnt = 0;
    ramp(0, 0);
    drain();
    check("stall_cycles", held_cnt >= 3, 1);
    check("stall_windows", win_cnt - start, 6);
    rdy_mode = 0;

    start = win_cnt;
    ramp(0, 0);
    ramp(100, 0);
    drain();
    check("b2b_windows", win_cnt - start, 12);

    start = win_cnt;
    for (int i = 0; i < 10; i++) send_pix(DW'(i), 0);
    clear = 1'b1; pix_valid = 1'b1; pix_in = 8'hAA;
    step();
    clear = 1'b0; pix_valid = 1'b0;
    mr = 0; mc = 0;
    check("clear_win_valid", win_valid, 0);
    check("clear_no_window", win_cnt - start, 0);
    ramp(0, 0);
    drain();
    check("clear_ramp_windows", win_cnt - start, 6);

    rdy_mode = 3;
    for (int i = 0; i < 13; i++) send_pix(DW'(i), 0);
    check("pre_reset_valid", win_valid, 1);
    reset = 1'b1;
    #1;
    check("reset_pix_ready", pix_ready, 0);
    exp_q.delete();
    step();
    check("reset_win_valid", win_valid, 0);
    check("reset_pix_ready_hold", pix_ready, 0);
    reset = 1'b0; rdy_mode = 0; mr = 0; mc = 0;
    step();
    start = win_cnt;
    ramp(0, 0);
    drain();
    check("post_reset_windows", win_cnt - start, 6);

    rdy_mode = 1; start = win_cnt;
    for (int f = 0; f < 3; f++)
      for (int p = 0; p < W * H; p++)
        send_pix(DW'($urandom_range(255, 0)), 1);
    drain();
    check("random_windows", win_cnt - start, 18);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
